// File: rtl/bcd_display_scan_if.sv
// Interface for the display scanner: the BCD frame coming in from the
// counter cascade and the multiplexed Nexys2 display pins going out.
//
// Signals:
//   digits    - four packed BCD digits, digit 0 in [3:0] (rightmost)
//   dp_in     - per-digit decimal point request, 1 = lit
//   enable    - 0 blanks the display while scanning keeps running
//   an        - anode selects, active-low, an[i] drives digit i
//   seg       - segments {g,f,e,d,c,b,a}, active-low
//   dp        - decimal point, active-low
//   scan_tick - one-cycle pulse on every digit-slot advance
//
// The master modport belongs to whoever supplies the digits; the slave
// modport is the scanner itself.
interface bcd_display_scan_if;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        enable;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        scan_tick;

  modport master (
    output digits, dp_in, enable,
    input  an, seg, dp, scan_tick
  );

  modport slave (
    input  digits, dp_in, enable,
    output an, seg, dp, scan_tick
  );
endinterface

// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed seven-segment scanner for the Nexys2 board.
//
// A prescaler divides clk down to one digit slot every REFRESH_DIV cycles.
// A 2-bit index walks the slots 0..3. At the start of every frame the
// incoming digits and decimal points are captured into a snapshot so a
// counter that changes mid-frame cannot tear the displayed value. The
// selected snapshot digit is decoded, optionally blanked as a leading zero,
// and registered onto the active-low an/seg/dp pins.
//
// Ports:
//   clk   - system clock, all logic on the rising edge
//   reset - asynchronous active-high reset, forces the display dark
//   bus   - slave side of bcd_display_scan_if (digits, dp_in, enable in;
//           an, seg, dp, scan_tick out)
//
// Parameters:
//   REFRESH_DIV - clk cycles per digit slot, must be 2 or greater
//   BLANK_LZ    - 1 blanks leading zeros in digits 3..1, 0 shows all digits
module bcd_display_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  bcd_display_scan_if.slave   bus
);

  localparam int              PW   = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]   LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic          r_scanTick;
  logic [15:0]   r_snapDigits;
  logic [3:0]    r_snapDp;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_wrap;
  logic          w_load;
  logic [15:0]   w_frameDigits;
  logic [3:0]    w_frameDp;
  logic [3:0]    w_digit;
  logic [6:0]    w_decoded;
  logic [3:0]    w_zero;
  logic [3:0]    w_blankVec;
  logic          w_blank;

  assign w_wrap = (r_presc == LAST);
  assign w_load = (r_presc == '0) && (r_idx == 2'd0);

  // Prescaler, slot index and the slot-advance pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc    <= '0;
      r_idx      <= 2'd0;
      r_scanTick <= 1'b0;
    end else if (w_wrap) begin
      r_presc    <= '0;
      r_idx      <= r_idx + 2'd1;
      r_scanTick <= 1'b1;
    end else begin
      r_presc    <= r_presc + 1'b1;
      r_scanTick <= 1'b0;
    end
  end

  // Frame snapshot, captured on the first cycle of slot 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snapDigits <= '0;
      r_snapDp     <= '0;
    end else if (w_load) begin
      r_snapDigits <= bus.digits;
      r_snapDp     <= bus.dp_in;
    end
  end

  // On the load cycle the value being captured is used directly, so the
  // whole visible frame, including its first output cycle, comes from one
  // snapshot.
  assign w_frameDigits = w_load ? bus.digits : r_snapDigits;
  assign w_frameDp     = w_load ? bus.dp_in  : r_snapDp;
  assign w_digit       = w_frameDigits[{r_idx, 2'b00} +: 4];

  // BCD to active-low segments; anything above 9 shows a dash.
  always_comb begin
    w_decoded = 7'b0111111;
    case (w_digit)
      4'd0: w_decoded = 7'b1000000;
      4'd1: w_decoded = 7'b1111001;
      4'd2: w_decoded = 7'b0100100;
      4'd3: w_decoded = 7'b0110000;
      4'd4: w_decoded = 7'b0011001;
      4'd5: w_decoded = 7'b0010010;
      4'd6: w_decoded = 7'b0000010;
      4'd7: w_decoded = 7'b1111000;
      4'd8: w_decoded = 7'b0000000;
      4'd9: w_decoded = 7'b0010000;
      default: w_decoded = 7'b0111111;
    endcase
  end

  // A digit is a leading zero when it and every digit to its left are zero
  // and its own decimal point is not requested. Digit 0 always shows.
  assign w_zero[0] = (w_frameDigits[3:0]   == 4'd0);
  assign w_zero[1] = (w_frameDigits[7:4]   == 4'd0);
  assign w_zero[2] = (w_frameDigits[11:8]  == 4'd0);
  assign w_zero[3] = (w_frameDigits[15:12] == 4'd0);

  assign w_blankVec[0] = 1'b0;
  assign w_blankVec[1] = w_zero[1] & w_zero[2] & w_zero[3] & ~w_frameDp[1];
  assign w_blankVec[2] = w_zero[2] & w_zero[3] & ~w_frameDp[2];
  assign w_blankVec[3] = w_zero[3] & ~w_frameDp[3];

  assign w_blank = BLANK_LZ & w_blankVec[r_idx];

  // Registered pin drivers; an and seg move on the same edge so a digit
  // never flashes with its neighbour's segments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else if (!bus.enable || w_blank) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= w_decoded;
      r_dp  <= ~w_frameDp[r_idx];
    end
  end

  assign bus.an        = r_an;
  assign bus.seg       = r_seg;
  assign bus.dp        = r_dp;
  assign bus.scan_tick = r_scanTick;

endmodule
